uart_rx: RTL

Serial UART receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first. It recovers bytes from an asynchronous `rx` line using an internal baud counter derived from the system clock. It pairs with the baud-tick generator and transmitter already in the design, acting as the receiving end of the same link. Output bytes are presented through a valid/ready handshake, with frame-error and overrun flags.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver, LSB first, with a valid/ready byte output.
//
// Recovers bytes from an asynchronous rx line using a baud counter derived
// from the system clock. The start bit is confirmed at half a bit time; the
// data and stop bits are then sampled every DIV clocks.
//
// Parameters
//   FBASE     system clock frequency in Hz
//   BAUDRATE  line bit rate in baud (FBASE / BAUDRATE must be >= 4)
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial line, idles high, asynchronous to clk
//   out_data   received byte, stable while out_valid = 1
//   out_valid  a byte is available
//   out_ready  consumer accepts the byte when out_valid & out_ready
//   frame_err  one-cycle pulse: the stop bit was sampled low
//   overrun    sticky: a byte completed while the previous one was unaccepted
module uart_rx #(
  parameter int FBASE    = 50_000_000,
  parameter int BAUDRATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV  = FBASE / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      sh_reg, sh_next;
  logic [7:0]      out_data_reg, out_data_next;
  logic            out_valid_reg, out_valid_next;
  logic            frame_err_reg, frame_err_next;
  logic            overrun_reg, overrun_next;
  logic [1:0]      sync_reg;
  logic            rx_s;

  // Two-stage synchronizer; both stages reset to the idle (high) level so a
  // reset release never looks like a start bit.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg[gi] <= 1'b1;
        end else begin
          sync_reg[gi] <= (gi == 0) ? rx : sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      sh_reg        <= '0;
      out_data_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      sh_reg        <= sh_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    sh_next        = sh_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    frame_err_next = 1'b0;
    overrun_next   = overrun_reg;

    // A handshake retires the current byte; a byte loaded below in the same
    // cycle overrides this and keeps out_valid high.
    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        // Level-triggered: a line held low re-arms immediately.
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == HALF_M1) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;  // too short to be a start bit
          end
        end
      end
      DATA: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == DIV_M1) begin
          cnt_next              = '0;
          sh_next[bit_idx_reg]  = rx_s;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == DIV_M1) begin
          // Return at mid-stop-bit so a following start edge is not missed.
          state_next = IDLE;
          cnt_next   = '0;
          if (rx_s) begin
            if (!out_valid_reg || out_ready) begin
              out_data_next  = sh_reg;
              out_valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;  // new byte dropped, old one kept
            end
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule
